// File: rtl/bch_31_decoder.sv
// BCH(31) double-error-correcting decoder: serial S1/S3 syndromes, closed-form
// locator classification, then a bit-serial Chien search that flips the erroneous bits.
module bch_31_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] rx_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] msg,
  output logic [1:0]  err_cnt,
  output logic        uncorrectable,
  output logic [2:0]  dbg_state
);

  localparam int          N    = 31;
  localparam int          K    = 20;
  localparam logic [5:0]  PRIM = 6'b100101;

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high; out_valid then stays high with msg/err_cnt/uncorrectable stable
  // until out_ready is seen.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYND  = 3'd1,
    CLASS = 3'd2,
    CHIEN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0] word_r;
  logic [K-1:0] orig_msg;
  logic [4:0]   s1, s3, c0, c1, c2, j;
  logic [1:0]   nu, roots;

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    p = '0;
    for (int i = 4; i >= 0; i--) begin
      p = {p[3:0], 1'b0} ^ (p[4] ? PRIM[4:0] : 5'b0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // alpha^5 = alpha^2 + 1
  function automatic logic [4:0] mul_a(input logic [4:0] b);
    return {b[3], b[2], b[1] ^ b[4], b[0], b[4]};
  endfunction

  // alpha^-1 = alpha^4 + alpha
  function automatic logic [4:0] mul_ainv(input logic [4:0] b);
    return {b[0], b[4], b[3], b[2] ^ b[0], b[1]};
  endfunction

  logic [4:0]   s1_sq, s1_cube;
  logic         hit;
  logic [N-1:0] word_fix;
  logic [1:0]   roots_nxt;

  always_comb begin
    s1_sq     = gf_mul(s1, s1);
    s1_cube   = gf_mul(s1_sq, s1);
    hit       = ((c0 ^ c1 ^ c2) == 5'd0);
    word_fix  = word_r ^ (hit ? (N'(1) << j) : '0);
    roots_nxt = roots + {1'b0, hit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SYND;
      SYND:    if (j == 5'd0) state_nxt = CLASS;
      CLASS:   state_nxt = (s1 == 5'd0) ? DONE : CHIEN;
      CHIEN:   if (j == 5'd30) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_r        <= '0;
      orig_msg      <= '0;
      s1            <= '0;
      s3            <= '0;
      c0            <= '0;
      c1            <= '0;
      c2            <= '0;
      j             <= '0;
      nu            <= '0;
      roots         <= '0;
      msg           <= '0;
      err_cnt       <= '0;
      uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word_r        <= rx_word;
          orig_msg      <= rx_word[N-1:N-K];
          s1            <= '0;
          s3            <= '0;
          j             <= 5'd30;
          err_cnt       <= '0;
          uncorrectable <= 1'b0;
        end
        SYND: begin
          s1 <= mul_a(s1) ^ {4'b0, word_r[j]};
          s3 <= mul_a(mul_a(mul_a(s3))) ^ {4'b0, word_r[j]};
          j  <= j - 5'd1;
        end
        CLASS: begin
          if (s1 == 5'd0) begin
            msg           <= word_r[N-1:N-K];
            err_cnt       <= '0;
            uncorrectable <= (s3 != 5'd0);
          end else begin
            // Locator scaled by S1: S1 + S1^2 x + (S1^3+S3) x^2, no inversion needed.
            nu    <= (s3 == s1_cube) ? 2'd1 : 2'd2;
            c0    <= s1;
            c1    <= s1_sq;
            c2    <= s1_cube ^ s3;
            j     <= '0;
            roots <= '0;
          end
        end
        CHIEN: begin
          word_r <= word_fix;
          roots  <= roots_nxt;
          c1     <= mul_ainv(c1);
          c2     <= mul_ainv(mul_ainv(c2));
          j      <= j + 5'd1;
          if (j == 5'd30) begin
            if (roots_nxt == nu) begin
              msg     <= word_fix[N-1:N-K];
              err_cnt <= nu;
            end else begin
              msg           <= orig_msg;
              err_cnt       <= '0;
              uncorrectable <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_31_decoder.sv
// Directed bench for bch_31_decoder: codewords come from an in-bench systematic
// encoder (division by g(x)), then known bit errors are injected.
module tb_bch_31_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] rx_word;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] msg;
  logic [1:0]  err_cnt;
  logic        uncorrectable;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [22:0] exp_q[$];

  bch_31_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_word(rx_word), .out_valid(out_valid), .out_ready(out_ready),
    .msg(msg), .err_cnt(err_cnt), .uncorrectable(uncorrectable),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1
  function automatic logic [30:0] bch_encode(input logic [19:0] m);
    logic [30:0] r;
    r = {m, 11'b0};
    for (int i = 30; i >= 10; i--)
      if (r[i]) r = r ^ (31'h769 << (i - 10));
    return {m, 11'b0} | r;
  endfunction

  task automatic run_word(input string tag, input logic [30:0] w, input logic [19:0] em,
                          input logic [1:0] ee, input logic eu, input int elat, input int hold);
    logic [22:0] e;
    int n;
    exp_q.push_back({eu, ee, em});
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    rx_word   = w;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_msg"}, 32'(msg), 32'(e[19:0]));
    check({tag, "_err"}, 32'(err_cnt), 32'(e[21:20]));
    check({tag, "_unc"}, 32'(uncorrectable), 32'(e[22]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_msg"}, 32'(msg), 32'(e[19:0]));
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [30:0] cw;
    logic [19:0] m;
    int p1, p2;
    rst = 1'b1; in_valid = 1'b0; rx_word = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_msg", 32'(msg), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_unc", 32'(uncorrectable), 32'd0);

    run_word("zero", 31'd0, 20'h0, 2'd0, 1'b0, 33, 0);
    run_word("clean", bch_encode(20'h5A5A5), 20'h5A5A5, 2'd0, 1'b0, 33, 0);
    run_word("one_err", bch_encode(20'hABCDE) ^ (31'd1 << 17), 20'hABCDE, 2'd1, 1'b0, 64, 0);
    run_word("two_err", bch_encode(20'h12345) ^ 31'h4000_0001, 20'h12345, 2'd2, 1'b0, 64, 0);
    run_word("s1_zero", 31'h25, 20'h0, 2'd0, 1'b1, 33, 0);
    run_word("hold", bch_encode(20'hABCDE) ^ (31'd1 << 17), 20'hABCDE, 2'd1, 1'b0, 64, 10);
    run_word("par_one", bch_encode(20'h0F0F0) ^ (31'd1 << 3), 20'h0F0F0, 2'd1, 1'b0, 64, 0);
    run_word("par_two", bch_encode(20'h55AA5) ^ (31'd1 << 9) ^ (31'd1 << 10), 20'h55AA5, 2'd2, 1'b0, 64, 0);
    run_word("msb_err", bch_encode(20'hFFFFF) ^ (31'd1 << 30), 20'hFFFFF, 2'd1, 1'b0, 64, 0);

    // Reset in the middle of a Chien-bound word: nothing may come out.
    @(negedge clk);
    rx_word = bch_encode(20'h12345) ^ 31'h4000_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_msg", 32'(msg), 32'd0);
    run_word("after_rst", bch_encode(20'h12345) ^ 31'h4000_0001, 20'h12345, 2'd2, 1'b0, 64, 0);

    for (int k = 0; k < 4; k++) begin
      m  = 20'($urandom_range(0, 20'hFFFFF));
      p1 = $urandom_range(0, 30);
      p2 = $urandom_range(0, 29);
      if (p2 >= p1) p2++;
      cw = bch_encode(m) ^ (31'd1 << p1) ^ (31'd1 << p2);
      run_word("rand_two", cw, m, 2'd2, 1'b0, 64, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
